fifo_write_arbiter: RTL and testbench

Write-side controller for the team's asynchronous FIFO. It shares the FIFO's single write port among N requesters with round-robin arbitration and drives `write_data`/`signal_write`. It never issues a write while `full` is high. It lives entirely in the `wclk` domain, directly in front of the FIFO's write interface.

---
 rtl/fifo_write_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the async FIFO write port among N requesters (wclk domain).
// Define WARB_BURST_EN to let a granted requester keep the port for up to BURST_LEN consecutive writes.
module fifo_write_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 2
) (
  input  logic                 wclk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         ack,
  output logic [DW-1:0]        write_data,
  output logic                 signal_write,
  input  logic                 full,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 stall
);
  localparam int unsigned GW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("fifo_write_arbiter: N must be in 2..8");
  end
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst
    $error("fifo_write_arbiter: BURST_LEN must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

  state_t        state, state_nxt;
  logic          eligible;
  logic          rr_found;
  logic [GW-1:0] cand, rr_win, win, grant_nxt;
  logic [DW-1:0] words [N];
  logic [DW-1:0] write_data_nxt;
  logic [N-1:0]  ack_nxt;
  logic          signal_write_nxt;

  assign eligible = (|req) && !full;
  assign stall    = (|req) && full;

  always_comb begin
    for (int i = 0; i < N; i++) words[i] = req_data[DW*i +: DW];
  end

  // First requester at or after grant_id+1, wrapping modulo N.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = grant_id;
    cand     = grant_id;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = GW'((32'(grant_id) + k) % N);
      if (!rr_found && req[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

`ifdef WARB_BURST_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt, win_cnt;
  logic          rehold;

  // A zero count only exists after reset, so the very first grant always rotates.
  assign rehold  = (burst_cnt != '0) && req[grant_id] && (burst_cnt < CW'(BURST_LEN));
  assign win     = rehold ? grant_id : rr_win;
  assign win_cnt = rehold ? burst_cnt + CW'(1) : CW'(1);

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) burst_cnt <= '0;
    else     burst_cnt <= burst_cnt_nxt;
  end
`else
  assign win = rr_win;
`endif

  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      signal_write <= 1'b0;
      ack          <= '0;
      write_data   <= '0;
      grant_id     <= GW'(N - 1);
    end else begin
      state        <= state_nxt;
      signal_write <= signal_write_nxt;
      ack          <= ack_nxt;
      write_data   <= write_data_nxt;
      grant_id     <= grant_nxt;
    end
  end

  // Decisions happen only from IDLE or SETTLE; ISSUE always hands over to SETTLE.
  always_comb begin
    state_nxt        = state;
    signal_write_nxt = 1'b0;
    ack_nxt          = '0;
    write_data_nxt   = write_data;
    grant_nxt        = grant_id;
`ifdef WARB_BURST_EN
    burst_cnt_nxt    = burst_cnt;
`endif
    case (state)
      IDLE, SETTLE: begin
        state_nxt = IDLE;
        if (eligible) begin
          state_nxt        = ISSUE;
          signal_write_nxt = 1'b1;
          ack_nxt          = N'(1) << win;
          write_data_nxt   = words[win];
          grant_nxt        = win;
`ifdef WARB_BURST_EN
          burst_cnt_nxt    = win_cnt;
`endif
        end
      end
      ISSUE:   state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random stimulus for fifo_write_arbiter with a FIFO model and scoreboard.
// Honours WARB_BURST_EN in its reference model.
module tb_fifo_write_arbiter;
  localparam int unsigned N         = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned BURST_LEN = 2;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned IW        = $clog2(N);

  logic          wclk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic [DW-1:0] write_data;
  logic          signal_write;
  logic          full;
  logic [IW-1:0] grant_id;
  logic          stall;

  fifo_write_arbiter #(.N(N), .DW(DW), .BURST_LEN(BURST_LEN)) dut (
    .wclk(wclk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .write_data(write_data), .signal_write(signal_write), .full(full),
    .grant_id(grant_id), .stall(stall)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] words [N][$];
  logic [DW-1:0] exp_q [N][$];
  logic [DW-1:0] wlog [$];
  logic [IW-1:0] wlog_id [$];
  int            rd_mode = 0;
  int            rd_req_cnt = 0;
  bit            rand_en = 1'b0;
  logic [N-1:0]  ack_seen = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] rr(input logic [N-1:0] r, input logic [IW-1:0] from);
    logic [IW-1:0] j;
    for (int unsigned k = 1; k <= N; k++) begin
      j = IW'((32'(from) + k) % N);
      if (r[j]) return j;
    end
    return from;
  endfunction

  task automatic push_word(input int i, input logic [DW-1:0] d);
    words[i].push_back(d);
    exp_q[i].push_back(d);
  endtask

  // One requester-side clock step: retire words whose ack cycle completed, then drive req/data.
  task automatic step();
    @(negedge wclk);
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && !rst && words[i].size() > 0) begin
        void'(words[i].pop_front());
        if (rand_en && $urandom_range(1) == 1) push_word(i, DW'($urandom));
      end
    end
    ack_seen = ack;
    for (int i = 0; i < N; i++) begin
      if (rand_en && words[i].size() == 0 && $urandom_range(3) == 0) push_word(i, DW'($urandom));
      req[i] = (words[i].size() != 0);
      req_data[DW*i +: DW] = req[i] ? words[i][0] : '0;
    end
  endtask

  // Monitor: FIFO model, reference arbiter and scoreboard, sampled 1 time unit after each posedge.
  initial begin
    logic [IW-1:0] last, w, pend_i;
    logic [DW-1:0] pend_d;
    int unsigned   bcnt;
    bit            prev_write, pend, any, exp_issue;
    int            fifo_cnt, rd_done;
    full = 1'b0; fifo_cnt = 0; rd_done = 0;
    last = IW'(N - 1); bcnt = 0; prev_write = 0; pend = 0; pend_i = '0; pend_d = '0;
    forever begin
      @(posedge wclk); #1;
      if (rst) begin
        chk("rst_signal_write", 32'(signal_write), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(N - 1));
        last = IW'(N - 1); bcnt = 0; prev_write = 0; pend = 0;
      end else begin
        any = |req;
        chk("stall", 32'(stall), 32'(any && full));
        exp_issue = any && !full && !prev_write;
        chk("signal_write", 32'(signal_write), 32'(exp_issue));
        if (exp_issue) begin
`ifdef WARB_BURST_EN
          if (bcnt > 0 && req[last] && bcnt < BURST_LEN) begin
            w = last; bcnt++;
          end else begin
            w = rr(req, last); bcnt = 1;
          end
`else
          w = rr(req, last);
`endif
          chk("ack", 32'(ack), 32'(N'(1) << w));
          chk("grant_id", 32'(grant_id), 32'(w));
          chk("write_data", 32'(write_data), 32'(exp_q[w][0]));
          last = w;
        end else begin
          chk("ack_idle", 32'(ack), 32'(0));
        end
        // The write issued at the previous edge lands in the FIFO on this edge.
        if (pend) begin
          chk("no_overflow", 32'(fifo_cnt < DEPTH), 32'(1));
          if (exp_q[pend_i].size() > 0) void'(exp_q[pend_i].pop_front());
          wlog.push_back(pend_d);
          wlog_id.push_back(pend_i);
          fifo_cnt++;
        end
        pend = exp_issue; pend_i = last; pend_d = write_data;
        prev_write = exp_issue;
        if (rd_done < rd_req_cnt && fifo_cnt > 0) begin
          fifo_cnt--; rd_done++;
        end else if (rd_mode == 2 && fifo_cnt > 0) begin
          fifo_cnt--;
        end else if (rd_mode == 1 && fifo_cnt > 0 && $urandom_range(2) == 0) begin
          fifo_cnt--;
        end
        full = (fifo_cnt >= DEPTH);
      end
    end
  end

  initial begin
    int n0, pending;
    bit seen;
    logic [DW-1:0] e;
    rst = 1'b1; req = '0; req_data = '0;
    repeat (3) step();
    chk("reset_write_data", 32'(write_data), 32'(0));
    chk("reset_stall", 32'(stall), 32'(0));
    rst = 1'b0;

    // Single requester, single word.
    n0 = wlog.size();
    push_word(0, 8'h11);
    repeat (8) step();
    chk("t1_write_count", 32'(wlog.size() - n0), 32'(1));
    chk("t1_data", 32'(wlog[n0]), 32'(8'h11));
    chk("t1_idle", 32'(signal_write), 32'(0));

    rd_mode = 2; repeat (4) step(); rd_mode = 0;
    rst = 1'b1; step(); rst = 1'b0;

    // All four requesting into an empty depth-8 FIFO with no reads.
    n0 = wlog.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_word(i, DW'(8'h20 + i));
    for (int i = 0; i < N; i++) push_word(i, DW'(8'h30 + i));
    repeat (30) step();
    chk("t2_write_count", 32'(wlog.size() - n0), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) begin
`ifdef WARB_BURST_EN
      e = DW'(8'h20 + k / 2);
`else
      e = DW'(8'h20 + k % N);
`endif
      chk("t2_order", 32'(wlog[n0 + k]), 32'(e));
    end
    chk("t2_stall", 32'(stall), 32'(1));
    chk("t2_no_strobe", 32'(signal_write), 32'(0));

    // One read frees one slot: exactly one more write, from requester 0.
    n0 = wlog.size();
    rd_req_cnt++;
    repeat (12) step();
    chk("t3_write_count", 32'(wlog.size() - n0), 32'(1));
    chk("t3_data", 32'(wlog[n0]), 32'(8'h30));
    chk("t3_full_again", 32'(full), 32'(1));
    chk("t3_stall", 32'(stall), 32'(1));

    // Drain, then reset during an ISSUE cycle.
    rd_mode = 2;
    repeat (20) step();
    push_word(0, 8'h3F);
    repeat (6) step();
    push_word(0, 8'h40); push_word(1, 8'h41); push_word(2, 8'h42);
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step();
      seen = signal_write;
    end
    chk("t4_issue_seen", 32'(seen), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_strobe", 32'(signal_write), 32'(0));
    chk("t4_rst_ack", 32'(ack), 32'(0));
    chk("t4_rst_grant", 32'(grant_id), 32'(N - 1));
    n0 = wlog.size();
    step();
    #2 rst = 1'b0;
    repeat (15) step();
    chk("t4_write_count", 32'(wlog.size() - n0), 32'(3));
    chk("t4_first_id", 32'(wlog_id[n0]), 32'(0));
    chk("t4_first_data", 32'(wlog[n0]), 32'(8'h40));

    // Lone requester 2 drops req after its ack.
    n0 = wlog.size();
    push_word(2, 8'h55);
    repeat (8) step();
    chk("t5_write_count", 32'(wlog.size() - n0), 32'(1));
    chk("t5_data", 32'(wlog[n0]), 32'(8'h55));
    chk("t5_id", 32'(wlog_id[n0]), 32'(2));
    chk("t5_idle", 32'(signal_write), 32'(0));

    // Random requests and reads.
    rand_en = 1'b1; rd_mode = 1;
    repeat (3000) step();
    rand_en = 1'b0; rd_mode = 2;
    repeat (60) step();
    pending = 0;
    for (int i = 0; i < N; i++) pending += exp_q[i].size() + words[i].size();
    chk("t6_all_delivered", 32'(pending), 32'(0));
    chk("t6_idle", 32'(signal_write), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
